nn_unpooling: RTL and testbench



---
 rtl/nn_unpooling_pkg.sv | 17 +
 rtl/nn_unpooling_linebuf_ram.sv | 30 +++
 rtl/nn_unpooling.sv | 106 ++++++++++
 tb/tb_nn_unpooling.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_unpooling_pkg.sv
// Shared helpers for the stream stages: ceiling log2 for port/address widths and the grid step of a level.
package nn_unpooling_pkg;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int grid_step(input int level);
        return 1 << level;
    endfunction

endpackage

// File: rtl/nn_unpooling_linebuf_ram.sv
// Simple dual-port line buffer: one write port, one registered read port, no reset on contents.
// Read data appears one cycle after the address; no backpressure.
module linebuf_ram
    import nn_unpooling_pkg::*;
#(
    parameter int  DEPTH     = 8,
    parameter int  BIT_WIDTH = 8,
    localparam int AW        = (clog2_f(DEPTH) > 0) ? clog2_f(DEPTH) : 1
) (
    input  logic                 clock,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [BIT_WIDTH-1:0] i_wr_dat,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [BIT_WIDTH-1:0] o_rd_dat
);

    logic [BIT_WIDTH-1:0] r_mem [DEPTH];
    logic [BIT_WIDTH-1:0] r_rd_dat;

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        r_rd_dat <= r_mem[i_rd_addr];
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/nn_unpooling.sv
// Nearest-neighbour 2x upsampler: replicates each pooled sample over its 2x2 block one grid level down.
// Latency 1 cycle (output coordinates trail input by S lines); no backpressure, full stream rate.
module nn_unpooling
    import nn_unpooling_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter int  HEIGHT     = 8,
    parameter int  W_WIDTH    = 10,
    parameter int  W_HEIGHT   = 10,
    parameter int  FIXED_BITW = 8,
    parameter int  UNITS      = 1,
    parameter int  LEVEL      = 0,
    localparam int VW         = clog2_f(W_HEIGHT),
    localparam int HW         = clog2_f(W_WIDTH),
    localparam int PW         = FIXED_BITW * UNITS
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          in_enable,
    input  logic [PW-1:0] in_pixels,
    input  logic [VW-1:0] in_vcnt,
    input  logic [HW-1:0] in_hcnt,
    output logic          out_enable,
    output logic [PW-1:0] out_pixels,
    output logic [VW-1:0] out_vcnt,
    output logic [HW-1:0] out_hcnt
);

    localparam int SHIFT = LEVEL + 1;
    localparam int S     = grid_step(SHIFT);
    localparam int DEPTH = WIDTH / S;
    localparam int AW    = (clog2_f(DEPTH) > 0) ? clog2_f(DEPTH) : 1;

    localparam logic [VW:0]   HEIGHT_X = (VW+1)'(HEIGHT);
    localparam logic [HW:0]   WIDTH_X  = (HW+1)'(WIDTH);
    localparam logic [VW-1:0] S_V      = VW'(S);
    localparam logic [VW-1:0] WRAP_V   = VW'(W_HEIGHT - S);
    localparam logic [VW-1:0] VMASK    = VW'((1 << LEVEL) - 1);
    localparam logic [HW-1:0] HMASK    = HW'((1 << LEVEL) - 1);

    logic          w_wr_en;
    logic          w_wr_bank;
    logic          w_rd_bank;
    logic [AW-1:0] w_addr;
    logic [VW-1:0] w_out_vcnt;
    logic          w_grid_ok;
    logic          w_out_range;
    logic          w_en_next;
    logic [PW-1:0] w_rd_dat;

    logic [1:0]    r_valid;
    logic          r_en;
    logic [VW-1:0] r_out_vcnt;
    logic [HW-1:0] r_out_hcnt;

    assign w_wr_en   = in_enable && !rst
                     && ({1'b0, in_vcnt} < HEIGHT_X)
                     && ({1'b0, in_hcnt} < WIDTH_X);
    assign w_wr_bank = in_vcnt[SHIFT];
    assign w_addr    = AW'(in_hcnt >> SHIFT);

    // Output lags by S lines; lines above S wrap into the bottom of the previous frame.
    assign w_out_vcnt = (in_vcnt >= S_V) ? (in_vcnt - S_V) : (in_vcnt + WRAP_V);

    // The block row being emitted was written one block row earlier, so its bank is never the write bank.
    assign w_rd_bank = w_out_vcnt[SHIFT];

    assign w_grid_ok   = ((w_out_vcnt & VMASK) == VMASK) && ((in_hcnt & HMASK) == HMASK);
    assign w_out_range = ({1'b0, w_out_vcnt} < HEIGHT_X) && ({1'b0, in_hcnt} < WIDTH_X);
    assign w_en_next   = w_grid_ok && w_out_range && r_valid[w_rd_bank];

    linebuf_ram #(
        .DEPTH     (2 << AW),
        .BIT_WIDTH (PW)
    ) u_linebuf (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({w_wr_bank, w_addr}),
        .i_wr_dat  (in_pixels),
        .i_rd_addr ({w_rd_bank, w_addr}),
        .o_rd_dat  (w_rd_dat)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_valid    <= '0;
            r_en       <= 1'b0;
            r_out_vcnt <= '0;
            r_out_hcnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_valid[w_wr_bank] <= 1'b1;
            end
            r_en       <= w_en_next;
            r_out_vcnt <= w_out_vcnt;
            r_out_hcnt <= in_hcnt;
        end
    end

    // Buffer contents survive reset, so the read word is masked rather than trusted.
    assign out_enable = r_en;
    assign out_pixels = r_en ? w_rd_dat : '0;
    assign out_vcnt   = r_out_vcnt;
    assign out_hcnt   = r_out_hcnt;

endmodule

// File: tb/tb_nn_unpooling.sv
// Directed bench: LEVEL=0 three-channel instance (with mid-frame reset) and LEVEL=1 single-channel instance.
module tb_nn_unpooling;

    logic        clock;
    logic        rst0, rst1;

    logic        in_en0, out_en0;
    logic [23:0] in_pix0, out_pix0;
    logic [3:0]  in_v0, in_h0, out_v0, out_h0;

    logic        in_en1, out_en1;
    logic [7:0]  in_pix1, out_pix1;
    logic [4:0]  in_v1, in_h1, out_v1, out_h1;

    int vectors     = 0;
    int miscompares = 0;
    int v0 = 0, h0 = 0, f0 = 0;
    int v1 = 0, h1 = 0, f1 = 0;
    int tick_n      = 0;
    int wrap_hits   = 0;
    int first_tick  = -1;
    bit seen_first  = 0;

    nn_unpooling #(
        .WIDTH(8), .HEIGHT(8), .W_WIDTH(10), .W_HEIGHT(10),
        .FIXED_BITW(8), .UNITS(3), .LEVEL(0)
    ) u0 (
        .clock(clock), .rst(rst0),
        .in_enable(in_en0), .in_pixels(in_pix0), .in_vcnt(in_v0), .in_hcnt(in_h0),
        .out_enable(out_en0), .out_pixels(out_pix0), .out_vcnt(out_v0), .out_hcnt(out_h0)
    );

    nn_unpooling #(
        .WIDTH(16), .HEIGHT(16), .W_WIDTH(20), .W_HEIGHT(20),
        .FIXED_BITW(8), .UNITS(1), .LEVEL(1)
    ) u1 (
        .clock(clock), .rst(rst1),
        .in_enable(in_en1), .in_pixels(in_pix1), .in_vcnt(in_v1), .in_hcnt(in_h1),
        .out_enable(out_en1), .out_pixels(out_pix1), .out_vcnt(out_v1), .out_hcnt(out_h1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pooled sample (r,c) of frame f: channel 0 carries the frame-dependent position code.
    function automatic logic [23:0] pix0(input int f, input int r, input int c);
        logic [7:0] a, b, d;
        a = 8'(16 * r + c + 64 * f);
        b = 8'(176 + c);
        d = 8'(192 + c);
        return {a, b, d};
    endfunction

    function automatic logic [7:0] pix1(input int f, input int r, input int c);
        return 8'(16 * r + c + 64 * f);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int          ov0, ov1;
        logic        e0, e1;
        logic [23:0] p0;
        logic [7:0]  p1;

        in_v0   = 4'(v0);
        in_h0   = 4'(h0);
        in_en0  = (v0 % 2 == 1) && (h0 % 2 == 1);
        in_pix0 = (v0 < 8 && h0 < 8) ? pix0(f0, v0 / 2, h0 / 2) : 24'($urandom);
        in_v1   = 5'(v1);
        in_h1   = 5'(h1);
        in_en1  = (v1 % 4 == 3) && (h1 % 4 == 3);
        in_pix1 = (v1 < 16 && h1 < 16) ? pix1(f1, v1 / 4, h1 / 4) : 8'($urandom);

        @(posedge clock);
        #1;

        if (rst0) begin
            check("mrst_en",   32'(out_en0),  32'(0));
            check("mrst_pix",  32'(out_pix0), 32'(0));
            check("mrst_vcnt", 32'(out_v0),   32'(0));
            check("mrst_hcnt", 32'(out_h0),   32'(0));
        end else begin
            ov0 = (v0 >= 2) ? v0 - 2 : v0 + 8;
            // After the mid-frame reset the bank feeding out row 3 is no longer trusted.
            e0  = (ov0 < 8) && (h0 < 8) && !(f0 == 2 && v0 == 5);
            p0  = e0 ? pix0(f0, ov0 / 2, h0 / 2) : 24'd0;
            check($sformatf("u0_en f%0d v%0d h%0d", f0, v0, h0),   32'(out_en0),  32'(e0));
            check($sformatf("u0_vcnt f%0d v%0d h%0d", f0, v0, h0), 32'(out_v0),   32'(ov0));
            check($sformatf("u0_hcnt f%0d v%0d h%0d", f0, v0, h0), 32'(out_h0),   32'(h0));
            check($sformatf("u0_pix f%0d v%0d h%0d", f0, v0, h0),  32'(out_pix0), 32'(p0));
            if (f0 == 0 && ov0 == 3 && h0 == 5) begin
                check("rep_3_5_ch0", 32'(out_pix0[23:16]), 32'h12);
                check("rep_3_5_ch1", 32'(out_pix0[15:8]),  32'hB2);
                check("rep_3_5_ch2", 32'(out_pix0[7:0]),   32'hC2);
            end
            if (f0 == 2 && ov0 == 0 && h0 == 0) begin
                check("neg_passthru", 32'(out_pix0[23:16]), 32'h80);
            end
            if (out_en0 === 1'b1 && (out_v0 == 4'd6 || out_v0 == 4'd7)) begin
                wrap_hits++;
            end
            if (!seen_first && out_en0 === 1'b1) begin
                seen_first = 1'b1;
                first_tick = tick_n;
                check("first_en_vcnt", 32'(out_v0),   32'(0));
                check("first_en_hcnt", 32'(out_h0),   32'(0));
                check("first_en_pix",  32'(out_pix0), 32'(pix0(0, 0, 0)));
            end
        end

        ov1 = (v1 >= 4) ? v1 - 4 : v1 + 16;
        e1  = (ov1 < 16) && (h1 < 16) && (ov1 % 2 == 1) && (h1 % 2 == 1);
        p1  = e1 ? pix1(f1, ov1 / 4, h1 / 4) : 8'd0;
        check($sformatf("u1_en f%0d v%0d h%0d", f1, v1, h1),   32'(out_en1),  32'(e1));
        check($sformatf("u1_vcnt f%0d v%0d h%0d", f1, v1, h1), 32'(out_v1),   32'(ov1));
        check($sformatf("u1_hcnt f%0d v%0d h%0d", f1, v1, h1), 32'(out_h1),   32'(h1));
        check($sformatf("u1_pix f%0d v%0d h%0d", f1, v1, h1),  32'(out_pix1), 32'(p1));
        if (f1 == 0 && ov1 == 7 && h1 == 13) begin
            check("lvl1_7_13", 32'(out_pix1), 32'h13);
        end

        tick_n++;
        h0++;
        if (h0 == 10) begin
            h0 = 0;
            v0++;
            if (v0 == 10) begin
                v0 = 0;
                f0++;
            end
        end
        h1++;
        if (h1 == 20) begin
            h1 = 0;
            v1++;
            if (v1 == 20) begin
                v1 = 0;
                f1++;
            end
        end
    endtask

    initial begin
        rst0    = 1'b1;
        rst1    = 1'b1;
        in_en0  = 1'b0;
        in_pix0 = '0;
        in_v0   = '0;
        in_h0   = '0;
        in_en1  = 1'b0;
        in_pix1 = '0;
        in_v1   = '0;
        in_h1   = '0;

        // Step 1: reset state of both instances.
        repeat (3) @(posedge clock);
        #1;
        check("rst_u0_en",   32'(out_en0),  32'(0));
        check("rst_u0_pix",  32'(out_pix0), 32'(0));
        check("rst_u0_vcnt", 32'(out_v0),   32'(0));
        check("rst_u0_hcnt", 32'(out_h0),   32'(0));
        check("rst_u1_en",   32'(out_en1),  32'(0));
        check("rst_u1_pix",  32'(out_pix1), 32'(0));
        check("rst_u1_vcnt", 32'(out_v1),   32'(0));
        check("rst_u1_hcnt", 32'(out_h1),   32'(0));
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Step 2: frames 0-1 of u0 (startup, replication, wrap rows).
        while (f0 < 2) begin
            tick();
        end

        // Step 3: frame 2 of u0 with a one-cycle reset at line 5, column 0.
        while (!(v0 == 5 && h0 == 0)) begin
            tick();
        end
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;

        // Step 4: run on until u1 has streamed three full frames.
        while (f1 < 3) begin
            tick();
        end

        // Step 5: aggregate checks.
        check("first_en_seen", 32'(seen_first), 32'(1));
        check("first_en_tick", 32'(first_tick), 32'(20));
        check("wrap_rows_6_7", 32'(wrap_hits),  32'(192));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
